window_match_engine: RTL and testbench
======================================

Name: window_match_engine

Overview:
- Consumer end of the window stream produced by the window handler.
- Accepts 16x16 8-bit-pixel windows as 64 beats of 32-bit words, with 4 pixels per word, little-end byte = lowest column.
- Computes the sum of absolute differences (SAD) of each window against a stored 16x16 template.
- Tracks the minimum-SAD window and its stream index, then reports the best match when the producer signals end of frame.

Parameters:
- BEATS_PER_WIN, 64, 32-bit beats per window (16 rows x 4 words).
- IDX_W, 13, width of the window index counter. Saturates at 2^IDX_W-1.
- SAD_W, 16, accumulator width. 256 px x 255 = 65280 fits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  start request for a new frame.
- ack  out  1  one-cycle pulse: start accepted.
- tmpl_data  in  32  template word, 4 pixels.
- tmpl_valid  in  1  tmpl_data valid this cycle.
- window_data  in  32  window beat, 4 pixels.
- window_ready  in  1  producer: window_data valid.
- receive  out  1  beat consumed this cycle.
- stream_done  in  1  producer end-of-frame pulse.
- busy  out  1  state != IDLE.
- best_sad  out  SAD_W  minimum SAD found.
- best_idx  out  IDX_W  index of best window, 0-based.
- result_valid  out  1  one-cycle pulse: best_* final.

Behaviour:
- Reset: state=IDLE. ack, receive, result_valid = 0. best_sad = all ones. best_idx = 0. All counters = 0. done_seen = 0.
- Template storage: 64x32 register array, written only in LOAD_TMPL.
- IDLE:
  - en=1 → ack=1 that cycle.
  - Clear best_sad to all ones, best_idx, win_cnt, beat_cnt, tptr, acc, done_seen.
  - Next state LOAD_TMPL.
- LOAD_TMPL:
  - Each tmpl_valid cycle writes tmpl[tptr], then tptr++.
  - The write with tptr=63 moves to ACCUM.
  - window_ready is ignored here (receive=0).
- ACCUM:
  - receive = window_ready (combinational, same cycle).
  - On a consumed beat: beat_sad = sum over bytes i of |window_data[8i+7:8i] - tmpl[beat_cnt][8i+7:8i]|, 10 bits unsigned.
  - acc += beat_sad. beat_cnt++.
  - The beat with beat_cnt=63 moves to COMPARE; beat_cnt wraps to 0.
  - If done_seen=1 and beat_cnt=0 → REPORT.
- COMPARE, 1 cycle, receive=0:
  - If acc < best_sad (strict), update best_sad=acc and best_idx=win_cnt. Ties keep the earlier index.
  - win_cnt++, saturating. acc=0.
  - Next state is REPORT if done_seen, else ACCUM.
- REPORT: result_valid=1 for one cycle → IDLE. best_sad and best_idx hold until the next ack.
- stream_done:
  - Sampled in any non-IDLE state into sticky done_seen.
  - If it arrives mid-window (beat_cnt != 0), the partial window is still finished when remaining beats arrive. The engine stops accepting beats after that window completes.
  - If it arrives during LOAD_TMPL, then after the template completes → ACCUM → REPORT immediately. Result in that case: best_sad = all ones, best_idx = 0.
- Simultaneous stream_done and last beat (beat_cnt=63): the beat is consumed, COMPARE runs, then REPORT.
- en while busy: ignored, no ack.
- rst asserted mid-operation: return to reset values next edge. Partial SAD and template pointer are discarded; template contents need not clear.
- Latency, last beat consumed → result_valid: 2 cycles (COMPARE, REPORT) when done_seen is already set.
- Throughput: 1 beat/cycle within a window, plus 1 bubble cycle (COMPARE) per window.

Optional Feature:
- WINDOW_MATCH_SAD_PIPE_EN defined:
  - beat_sad is registered before accumulation (adds 1 pipeline stage).
  - ACCUM → DRAIN (1 cycle, receive=0, final beat added) → COMPARE.
  - Last-beat-to-result_valid latency becomes 3 cycles; per-window bubble becomes 2 cycles.
- Undefined: beat_sad feeds acc combinationally; no DRAIN state.

Test Plan:
- Template all 0x10. One window all 0x10, then stream_done → best_sad=0, best_idx=0, result_valid 2 cycles after last receive.
- Template all 0x10. Windows of all 0x00, 0x12, 0x0F, then done:
  - SADs are 4096, 512, 256.
  - Expect best_sad=256, best_idx=2.
- Two identical windows with SAD 100 → best_idx=0 (tie keeps first).
- Extremes:
  - Template all 0x00, window all 0xFF → best_sad=65280, no overflow.
  - Template all 0xFF, window all 0x00 → same.
- stream_done pulsed at beat 30 of window 1 → window 1 completes after beats 31-63. result_valid follows, win_cnt=2, no further receive.
- rst high at beat 20 of window 0 → all outputs return to reset values. A new en yields ack. A full rerun gives the same result as a clean run.

Source files
------------

// File: rtl/window_match_engine.sv
// Window SAD match engine: loads a 16x16 template, then scores streamed windows.
// It tracks the minimum-SAD window and reports it at end of frame.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en / ack          frame start request / one-cycle accept pulse
//   tmpl_data/valid   template words (4 px, byte 0 = lowest column)
//   window_data/ready window beats from the producer
//   receive           beat consumed this cycle (combinational on window_ready)
//   stream_done       producer end-of-frame pulse (sticky once seen)
//   busy              engine not idle
//   best_sad/best_idx minimum SAD and its 0-based window index
//   result_valid      one-cycle pulse when best_* are final
//
// Optional build macro WINDOW_MATCH_SAD_PIPE_EN registers beat_sad ahead
// of the accumulator and adds a DRAIN state after each window's last beat.

module window_match_engine #(
  parameter int BEATS_PER_WIN = 64,
  parameter int IDX_W         = 13,
  parameter int SAD_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             ack,
  input  logic [31:0]      tmpl_data,
  input  logic             tmpl_valid,
  input  logic [31:0]      window_data,
  input  logic             window_ready,
  output logic             receive,
  input  logic             stream_done,
  output logic             busy,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             result_valid
);

  localparam int BW = $clog2(BEATS_PER_WIN);
  localparam logic [BW-1:0] LAST = BW'(BEATS_PER_WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCUM,
    S_DRAIN,
    S_CMP,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0]    tptr_q, tptr_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [SAD_W-1:0] acc_q, acc_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             done_q, done_d;

  logic [31:0] tmpl_q [BEATS_PER_WIN];
  logic        tmpl_we;
  logic [31:0] tmpl_word;
  logic [9:0]  beat_sad;

`ifdef WINDOW_MATCH_SAD_PIPE_EN
  logic [9:0] sad_q, sad_d;
  logic       sad_vld_q, sad_vld_d;
`endif

  // Template store has no reset; contents are rewritten every frame.
  always_ff @(posedge clk) begin
    if (tmpl_we) begin
      tmpl_q[tptr_q] <= tmpl_data;
    end
  end

  // Per-beat SAD over the four byte lanes.
  always_comb begin
    logic [7:0] px_w;
    logic [7:0] px_t;
    logic [7:0] px_d;
    tmpl_word = tmpl_q[beat_q];
    beat_sad  = '0;
    for (int i = 0; i < 4; i++) begin
      px_w = window_data[8*i +: 8];
      px_t = tmpl_word[8*i +: 8];
      px_d = (px_w >= px_t) ? (px_w - px_t) : (px_t - px_w);
      beat_sad = beat_sad + {2'b00, px_d};
    end
  end

  always_comb begin
    state_d    = state_q;
    tptr_d     = tptr_q;
    beat_d     = beat_q;
    win_d      = win_q;
    acc_d      = acc_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    done_d     = done_q | (stream_done & (state_q != S_IDLE));
    ack        = 1'b0;
    receive    = 1'b0;
    result_valid = 1'b0;
    tmpl_we    = 1'b0;
`ifdef WINDOW_MATCH_SAD_PIPE_EN
    sad_d      = sad_q;
    sad_vld_d  = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          ack        = 1'b1;
          best_sad_d = '1;
          best_idx_d = '0;
          win_d      = '0;
          beat_d     = '0;
          tptr_d     = '0;
          acc_d      = '0;
          done_d     = 1'b0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        if (tmpl_valid) begin
          tmpl_we = 1'b1;
          tptr_d  = tptr_q + BW'(1);
          if (tptr_q == LAST) begin
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
`ifdef WINDOW_MATCH_SAD_PIPE_EN
        if (sad_vld_q) begin
          acc_d = acc_q + SAD_W'(sad_q);
        end
`endif
        // End of frame only on a window boundary, so partial windows finish.
        if (done_q && (beat_q == '0)) begin
          state_d = S_REPORT;
        end else begin
          receive = window_ready;
          if (window_ready) begin
`ifdef WINDOW_MATCH_SAD_PIPE_EN
            sad_d     = beat_sad;
            sad_vld_d = 1'b1;
`else
            acc_d = acc_q + SAD_W'(beat_sad);
`endif
            if (beat_q == LAST) begin
              beat_d = '0;
`ifdef WINDOW_MATCH_SAD_PIPE_EN
              state_d = S_DRAIN;
`else
              state_d = S_CMP;
`endif
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
      end

`ifdef WINDOW_MATCH_SAD_PIPE_EN
      S_DRAIN: begin
        if (sad_vld_q) begin
          acc_d = acc_q + SAD_W'(sad_q);
        end
        state_d = S_CMP;
      end
`endif

      S_CMP: begin
        // Strict compare: ties keep the earlier window.
        if (acc_q < best_sad_q) begin
          best_sad_d = acc_q;
          best_idx_d = win_q;
        end
        if (win_q != '1) begin
          win_d = win_q + IDX_W'(1);
        end
        acc_d   = '0;
        state_d = done_q ? S_REPORT : S_ACCUM;
      end

      S_REPORT: begin
        result_valid = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tptr_q     <= '0;
      beat_q     <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tptr_q     <= tptr_d;
      beat_q     <= beat_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      done_q     <= done_d;
    end
  end

`ifdef WINDOW_MATCH_SAD_PIPE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sad_q     <= '0;
      sad_vld_q <= 1'b0;
    end else begin
      sad_q     <= sad_d;
      sad_vld_q <= sad_vld_d;
    end
  end
`endif

  assign busy     = (state_q != S_IDLE);
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule

// File: tb/tb_window_match_engine.sv
// Directed bench for window_match_engine.
// Vector table of uniform-fill frames plus hand-written reset/early-done cases.

module tb_window_match_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ack;
  logic [31:0] tmpl_data;
  logic        tmpl_valid;
  logic [31:0] window_data;
  logic        window_ready;
  logic        receive;
  logic        stream_done;
  logic        busy;
  logic [15:0] best_sad;
  logic [12:0] best_idx;
  logic        result_valid;

`ifdef WINDOW_MATCH_SAD_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  window_match_engine dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ack          (ack),
    .tmpl_data    (tmpl_data),
    .tmpl_valid   (tmpl_valid),
    .window_data  (window_data),
    .window_ready (window_ready),
    .receive      (receive),
    .stream_done  (stream_done),
    .busy         (busy),
    .best_sad     (best_sad),
    .best_idx     (best_idx),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      t;
    int              n;
    logic [2:0][7:0] fill;
    logic [2:0][7:0] first;
    int              done_at;
    int              exp_sad;
    int              exp_idx;
    int              exp_rx;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic [7:0] t, input int n,
    input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
    input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
    input int done_at, input int s, input int idx, input int rx);
    vec_t v;
    v.t        = t;
    v.n        = n;
    v.fill[0]  = f0;
    v.fill[1]  = f1;
    v.fill[2]  = f2;
    v.first[0] = a0;
    v.first[1] = a1;
    v.first[2] = a2;
    v.done_at  = done_at;
    v.exp_sad  = s;
    v.exp_idx  = idx;
    v.exp_rx   = rx;
    return v;
  endfunction

  // Window w: every pixel = fill[w], except pixel (row 0, col 0) = first[w].
  function automatic logic [31:0] word_of(input vec_t v, input int g);
    int w;
    int b;
    logic [7:0] f;
    logic [7:0] p0;
    w = g / 64;
    b = g % 64;
    if (w >= v.n) w = v.n - 1;
    f  = v.fill[w];
    p0 = (b == 0) ? v.first[w] : f;
    return {f, f, f, p0};
  endfunction

  task automatic start_frame();
    @(negedge clk);
    en = 1'b1;
    #1;
    chk("ack_on_en", int'(ack), 1);
    @(posedge clk);
  endtask

  task automatic load_tmpl(input logic [7:0] t, input int done_i);
    int rx;
    rx = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      en           = (i == 5);
      tmpl_valid   = 1'b1;
      tmpl_data    = {4{t}};
      window_ready = 1'b1;
      window_data  = 32'h0;
      stream_done  = (i == done_i);
      #1;
      if (receive) rx++;
      if (i == 5) chk("no_ack_busy", int'(ack), 0);
      @(posedge clk);
    end
    chk("rx_in_load", rx, 0);
  endtask

  task automatic stream(input string tag, input vec_t v);
    int g;
    int last;
    int lat;
    bit got;
    g    = 0;
    last = -1;
    lat  = -1;
    got  = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      en           = 1'b0;
      tmpl_valid   = 1'b0;
      window_ready = ((c % 7) != 3);
      window_data  = word_of(v, g);
      stream_done  = (g == v.done_at);
      #1;
      if (result_valid) begin
        got = 1'b1;
        lat = c - last;
      end
      if (receive) begin
        g++;
        last = c;
      end
      @(posedge clk);
    end
    chk({tag, "_rv_seen"}, int'(got), 1);
    chk({tag, "_rx_count"}, g, v.exp_rx);
    chk({tag, "_best_sad"}, int'(best_sad), v.exp_sad);
    chk({tag, "_best_idx"}, int'(best_idx), v.exp_idx);
    if (v.exp_rx > 0) chk({tag, "_latency"}, lat, LAT);
    @(negedge clk);
    window_ready = 1'b1;
    stream_done  = 1'b0;
    #1;
    chk({tag, "_rv_pulse"}, int'(result_valid), 0);
    chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_hold_sad"}, int'(best_sad), v.exp_sad);
    window_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    start_frame();
    load_tmpl(v.t, -1);
    stream(tag, v);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sad"}, int'(best_sad), 16'hFFFF);
    chk({tag, "_idx"}, int'(best_idx), 0);
    chk({tag, "_rv"}, int'(result_valid), 0);
    chk({tag, "_rx"}, int'(receive), 0);
  endtask

  initial begin
    vec_t vd;
    int   g;

    rst          = 1'b1;
    en           = 1'b0;
    tmpl_data    = '0;
    tmpl_valid   = 1'b0;
    window_data  = '0;
    window_ready = 1'b1;
    stream_done  = 1'b0;

    vecs[0] = mkv(8'h10, 1, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
                  63, 0, 0, 64);
    vecs[1] = mkv(8'h10, 3, 8'h00, 8'h12, 8'h0F, 8'h00, 8'h12, 8'h0F,
                  191, 256, 2, 192);
    vecs[2] = mkv(8'h10, 2, 8'h10, 8'h10, 8'h10, 8'h74, 8'h74, 8'h10,
                  127, 100, 0, 128);
    vecs[3] = mkv(8'h10, 2, 8'h10, 8'h10, 8'h10, 8'h74, 8'h73, 8'h10,
                  127, 99, 1, 128);
    vecs[4] = mkv(8'h00, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  63, 65280, 0, 64);
    vecs[5] = mkv(8'hFF, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  63, 65280, 0, 64);
    vecs[6] = mkv(8'h80, 2, 8'h80, 8'h81, 8'h80, 8'h00, 8'h80, 8'h80,
                  127, 128, 0, 128);
    vecs[7] = mkv(8'h10, 3, 8'h12, 8'h11, 8'h10, 8'h12, 8'h11, 8'h10,
                  94, 256, 1, 128);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_state("reset");
    chk("reset_ack", int'(ack), 0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_vec($sformatf("vec%0d", k), vecs[k]);
    end

    // stream_done during template load: no window consumed.
    vd = mkv(8'h10, 1, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
             -1, 16'hFFFF, 0, 0);
    start_frame();
    load_tmpl(8'h10, 10);
    stream("done_in_load", vd);

    // Reset at beat 20 of window 0, then a clean rerun.
    start_frame();
    load_tmpl(8'h10, -1);
    g = 0;
    for (int c = 0; c < 100 && g < 20; c++) begin
      @(negedge clk);
      tmpl_valid   = 1'b0;
      en           = 1'b0;
      window_ready = 1'b1;
      window_data  = word_of(vecs[1], g);
      #1;
      if (receive) g++;
      @(posedge clk);
    end
    chk("pre_rst_beats", g, 20);
    @(negedge clk);
    window_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    run_vec("rerun", vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
